// File: rtl/graph_pkg.sv
// rtl/graph_pkg.sv - shared types and node placement helpers for the graph loader and PageRank engine
package graph_pkg;

   typedef logic [31:0] node_id_t;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      LOAD,
      DONE
   } loader_state_t;

   function automatic int node_to_thread(input int n, input int nodes_in_partition);
      return n / nodes_in_partition;
   endfunction

   function automatic int node_to_slot(input int n, input int nodes_in_partition);
      return n % nodes_in_partition;
   endfunction

endpackage

// File: rtl/graph_loader_serial.sv
// rtl/graph_loader_serial.sv - serial edge loader building partitioned adjacency arrays
module graph_loader_serial
   import graph_pkg::*;
#(
   parameter int NUM_HW_THREADS     = 20,
   parameter int NODES_IN_PARTITION = 1,
   parameter int NODES_IN_GRAPH     = 20,
   parameter int STREAM_SIZE        = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_start,
   input  logic        edge_valid,
   output logic        edge_ready,
   input  node_id_t    edge_src,
   input  node_id_t    edge_dst,
   input  logic        edge_last,
   output node_id_t    source_id  [NUM_HW_THREADS][NODES_IN_PARTITION],
   output logic [31:0] out_degree [NUM_HW_THREADS][NODES_IN_PARTITION],
   output node_id_t    dest_id    [NUM_HW_THREADS][NODES_IN_PARTITION][STREAM_SIZE],
   output logic        graph_valid,
   output logic [31:0] edge_count,
   output logic        overflow_err,
   output logic        range_err
);

   localparam int       NW         = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
   localparam int       DW         = (STREAM_SIZE > 1) ? $clog2(STREAM_SIZE) : 1;
   localparam node_id_t NODE_LIMIT = node_id_t'(NODES_IN_GRAPH);
   localparam logic [NW-1:0] LAST_NODE = NW'(NODES_IN_GRAPH - 1);

   if (NODES_IN_GRAPH != NUM_HW_THREADS * NODES_IN_PARTITION) begin : g_bad_geometry
      $error("NODES_IN_GRAPH must equal NUM_HW_THREADS*NODES_IN_PARTITION");
   end

   loader_state_t state_q, state_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [31:0]   ecnt_q, ecnt_d;
   logic          ovf_q, ovf_d;
   logic          rng_q, rng_d;

   // Storage is flat by node id; the thread/slot view is pure wiring below.
   node_id_t    src_q [NODES_IN_GRAPH];
   node_id_t    src_d [NODES_IN_GRAPH];
   logic [31:0] deg_q [NODES_IN_GRAPH];
   logic [31:0] deg_d [NODES_IN_GRAPH];
   node_id_t    dst_q [NODES_IN_GRAPH][STREAM_SIZE];
   node_id_t    dst_d [NODES_IN_GRAPH][STREAM_SIZE];

   logic [NW-1:0] src_idx;
   logic [DW-1:0] slot_idx;

   assign src_idx  = edge_src[NW-1:0];
   assign slot_idx = deg_q[src_idx][DW-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ecnt_q  <= '0;
         ovf_q   <= 1'b0;
         rng_q   <= 1'b0;
         for (int n = 0; n < NODES_IN_GRAPH; n++) begin
            src_q[n] <= '0;
            deg_q[n] <= '0;
            for (int k = 0; k < STREAM_SIZE; k++) begin
               dst_q[n][k] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ecnt_q  <= ecnt_d;
         ovf_q   <= ovf_d;
         rng_q   <= rng_d;
         src_q   <= src_d;
         deg_q   <= deg_d;
         dst_q   <= dst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ecnt_d  = ecnt_q;
      ovf_d   = ovf_q;
      rng_d   = rng_q;
      src_d   = src_q;
      deg_d   = deg_q;
      dst_d   = dst_q;

      case (state_q)
         IDLE, DONE: begin
            if (load_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
               ecnt_d  = '0;
               ovf_d   = 1'b0;
               rng_d   = 1'b0;
            end
         end
         CLEAR: begin
            src_d[cnt_q] = node_id_t'(cnt_q);
            deg_d[cnt_q] = '0;
            for (int k = 0; k < STREAM_SIZE; k++) begin
               dst_d[cnt_q][k] = '0;
            end
            if (cnt_q == LAST_NODE) begin
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOAD: begin
            if (edge_valid) begin
               if (edge_src >= NODE_LIMIT || edge_dst >= NODE_LIMIT) begin
                  rng_d = 1'b1;
               end else if (deg_q[src_idx] == 32'(STREAM_SIZE)) begin
                  ovf_d = 1'b1;
               end else begin
                  dst_d[src_idx][slot_idx] = edge_dst;
                  deg_d[src_idx]           = deg_q[src_idx] + 32'd1;
                  ecnt_d                   = ecnt_q + 32'd1;
               end
               // A dropped final edge still terminates the load.
               if (edge_last) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign edge_ready   = (state_q == LOAD);
   assign graph_valid  = (state_q == DONE);
   assign edge_count   = ecnt_q;
   assign overflow_err = ovf_q;
   assign range_err    = rng_q;

   for (genvar n = 0; n < NODES_IN_GRAPH; n++) begin : g_map
      localparam int T = node_to_thread(n, NODES_IN_PARTITION);
      localparam int S = node_to_slot(n, NODES_IN_PARTITION);
      assign source_id[T][S]  = src_q[n];
      assign out_degree[T][S] = deg_q[n];
      for (genvar k = 0; k < STREAM_SIZE; k++) begin : g_dst
         assign dest_id[T][S][k] = dst_q[n][k];
      end
   end

endmodule

// File: tb/tb_graph_loader_serial.sv
// tb/tb_graph_loader_serial.sv - scoreboard bench for graph_loader_serial
module tb_graph_loader_serial;
   import graph_pkg::*;

   localparam int NT = 20;
   localparam int NP = 1;
   localparam int NG = 20;
   localparam int SS = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        load_start = 1'b0;
   logic        edge_valid = 1'b0;
   logic        edge_ready;
   logic [31:0] edge_src = '0;
   logic [31:0] edge_dst = '0;
   logic        edge_last = 1'b0;
   logic [31:0] source_id  [NT][NP];
   logic [31:0] out_degree [NT][NP];
   logic [31:0] dest_id    [NT][NP][SS];
   logic        graph_valid;
   logic [31:0] edge_count;
   logic        overflow_err;
   logic        range_err;

   graph_loader_serial #(
      .NUM_HW_THREADS(NT), .NODES_IN_PARTITION(NP), .NODES_IN_GRAPH(NG), .STREAM_SIZE(SS)
   ) dut (
      .clock(clock), .reset(reset), .load_start(load_start),
      .edge_valid(edge_valid), .edge_ready(edge_ready),
      .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
      .source_id(source_id), .out_degree(out_degree), .dest_id(dest_id),
      .graph_valid(graph_valid), .edge_count(edge_count),
      .overflow_err(overflow_err), .range_err(range_err)
   );

   initial forever #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ls_cyc   = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // kind: 0 edge_count, 1 overflow_err, 2 range_err, 3 out_degree, 4 dest_id, 5 source_id, 6 latency
   typedef struct {
      int          kind;
      int          a;
      int          b;
      logic [31:0] exp;
   } chk_t;

   chk_t sb[$];

   int bsrc [31] = '{0,0,0, 1,1, 2, 3, 4, 5,5, 6,6, 7,7, 8,8, 9,9, 10,10, 11,11, 12,12, 13,13, 14,14, 15,15, 18};
   int bdst [31] = '{1,4,5, 2,6, 3, 7, 8, 6,9, 7,10, 8,11, 9,12, 10,13, 11,14, 12,15, 13,16, 14,17, 15,18, 16,19, 19};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void expect_item(input int kind, input int a, input int b, input logic [31:0] e);
      chk_t c;
      c.kind = kind; c.a = a; c.b = b; c.exp = e;
      sb.push_back(c);
   endfunction

   function automatic logic [31:0] actual(input chk_t c);
      case (c.kind)
         0: return edge_count;
         1: return {31'd0, overflow_err};
         2: return {31'd0, range_err};
         3: return out_degree[c.a][0];
         4: return dest_id[c.a][0][c.b];
         5: return source_id[c.a][0];
         default: return 32'(cyc - ls_cyc);
      endcase
   endfunction

   function automatic string kname(input chk_t c);
      string names [7] = '{"edge_count", "overflow_err", "range_err", "out_degree",
                           "dest_id", "source_id", "valid_latency"};
      return $sformatf("%s[%0d][%0d]", names[c.kind], c.a, c.b);
   endfunction

   logic gv_prev = 1'b0;
   always @(negedge clock) begin
      chk_t c;
      if (graph_valid && !gv_prev) begin
         while (sb.size() > 0) begin
            c = sb.pop_front();
            chk(kname(c), actual(c), c.exp);
         end
      end
      gv_prev = graph_valid;
   end

   task automatic start_load();
      @(posedge clock); #1;
      load_start = 1'b1;
      ls_cyc = cyc;
      @(posedge clock); #1;
      load_start = 1'b0;
      chk("graph_valid_after_start", {31'd0, graph_valid}, 32'd0);
   endtask

   task automatic send(input logic [31:0] s, input logic [31:0] d, input logic l);
      bit ok = 1'b0;
      edge_valid = 1'b1; edge_src = s; edge_dst = d; edge_last = l;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clock);
         if (edge_ready) begin
            ok = 1'b1;
            @(posedge clock); #1;
         end
      end
      edge_valid = 1'b0; edge_last = 1'b0;
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
      if (sb.size() > 0) begin
         chk("graph_valid_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      int zeros;
      bit seen;

      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset_graph_valid", {31'd0, graph_valid}, 32'd0);
      chk("reset_edge_ready", {31'd0, edge_ready}, 32'd0);
      chk("reset_edge_count", edge_count, 32'd0);
      chk("reset_errs", {30'd0, overflow_err, range_err}, 32'd0);
      chk("reset_source_id5", source_id[5][0], 32'd0);

      // Benchmark graph
      expect_item(0, 0, 0, 32'd31);
      expect_item(1, 0, 0, 32'd0);
      expect_item(2, 0, 0, 32'd0);
      expect_item(3, 0, 0, 32'd3);
      expect_item(3, 19, 0, 32'd0);
      expect_item(3, 16, 0, 32'd0);
      expect_item(3, 2, 0, 32'd1);
      expect_item(4, 15, 0, 32'd16);
      expect_item(4, 15, 1, 32'd19);
      expect_item(4, 15, 2, 32'd0);
      expect_item(4, 0, 2, 32'd5);
      expect_item(5, 19, 0, 32'd19);
      expect_item(6, 0, 0, 32'd52);
      start_load();
      for (int i = 0; i < 31; i++) send(bsrc[i], bdst[i], i == 30);
      drain();

      // Overflow, reloaded from DONE
      expect_item(3, 0, 0, 32'd3);
      expect_item(4, 0, 0, 32'd1);
      expect_item(4, 0, 1, 32'd2);
      expect_item(4, 0, 2, 32'd3);
      expect_item(1, 0, 0, 32'd1);
      expect_item(2, 0, 0, 32'd0);
      expect_item(0, 0, 0, 32'd3);
      expect_item(3, 15, 0, 32'd0);
      expect_item(4, 15, 0, 32'd0);
      expect_item(6, 0, 0, 32'd25);
      start_load();
      send(0, 1, 1'b0);
      send(0, 2, 1'b0);
      send(0, 3, 1'b0);
      send(0, 4, 1'b1);
      drain();

      // Range errors, both edges dropped
      expect_item(2, 0, 0, 32'd1);
      expect_item(1, 0, 0, 32'd0);
      expect_item(0, 0, 0, 32'd0);
      for (int k = 0; k < NG; k++) begin
         expect_item(3, k, 0, 32'd0);
         expect_item(5, k, 0, 32'(k));
      end
      expect_item(6, 0, 0, 32'd23);
      start_load();
      send(20, 1, 1'b0);
      send(3, 25, 1'b1);
      drain();

      // Backpressure: valid held from the load_start cycle
      expect_item(3, 7, 0, 32'd1);
      expect_item(4, 7, 0, 32'd3);
      expect_item(4, 7, 1, 32'd0);
      expect_item(0, 0, 0, 32'd1);
      expect_item(6, 0, 0, 32'd22);
      @(posedge clock); #1;
      load_start = 1'b1; ls_cyc = cyc;
      edge_valid = 1'b1; edge_src = 7; edge_dst = 3; edge_last = 1'b1;
      zeros = 0; seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clock);
         if (edge_ready) seen = 1'b1;
         else zeros++;
         @(posedge clock); #1;
         load_start = 1'b0;
      end
      edge_valid = 1'b0; edge_last = 1'b0;
      chk("backpressure_not_ready_cycles", 32'(zeros), 32'd21);
      drain();

      // Reset in the middle of LOAD
      start_load();
      for (int i = 0; i < 5; i++) send(bsrc[i], bdst[i], 1'b0);
      reset = 1'b1;
      @(negedge clock);
      chk("midreset_state", 32'(dut.state_q), 32'(IDLE));
      chk("midreset_graph_valid", {31'd0, graph_valid}, 32'd0);
      chk("midreset_edge_ready", {31'd0, edge_ready}, 32'd0);
      chk("midreset_edge_count", edge_count, 32'd0);
      chk("midreset_out_degree0", out_degree[0][0], 32'd0);
      chk("midreset_out_degree1", out_degree[1][0], 32'd0);
      chk("midreset_dest_id0", dest_id[0][0][0], 32'd0);
      for (int k = 0; k < NG; k++) chk($sformatf("midreset_source_id%0d", k), source_id[k][0], 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Fresh two-edge graph with a self-loop
      expect_item(0, 0, 0, 32'd2);
      expect_item(3, 4, 0, 32'd2);
      expect_item(4, 4, 0, 32'd5);
      expect_item(4, 4, 1, 32'd4);
      expect_item(4, 4, 2, 32'd0);
      expect_item(3, 0, 0, 32'd0);
      expect_item(2, 0, 0, 32'd0);
      expect_item(6, 0, 0, 32'd23);
      start_load();
      send(4, 5, 1'b0);
      send(4, 4, 1'b1);
      drain();
      repeat (3) @(negedge clock);
      chk("done_hold_graph_valid", {31'd0, graph_valid}, 32'd1);
      chk("done_hold_edge_ready", {31'd0, edge_ready}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/graph_loader_serial.md
Name: graph_loader_serial

Overview:
- Upstream feeder for pagerank_DMP_serial.
- Accepts a serial stream of directed edges (src, dst) over a valid/ready handshake.
- Builds the partitioned adjacency arrays source_id, out_degree and dest_id that the PageRank engine consumes.
- Asserts graph_valid once the final edge is stored; graph_valid drives the engine's pagerank_enable.

Parameters:
- NUM_HW_THREADS, 20, number of hardware threads (first array dimension).
- NODES_IN_PARTITION, 1, nodes per thread (second dimension).
- NODES_IN_GRAPH, 20, total nodes; must equal NUM_HW_THREADS*NODES_IN_PARTITION (elaboration-time assertion).
- STREAM_SIZE, 3, maximum out-edges stored per node.

Ports:
- clock, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- load_start, input, 1, single-cycle pulse that begins a (re)load.
- edge_valid, input, 1, edge beat is valid.
- edge_ready, output, 1, loader accepts an edge this cycle.
- edge_src, input, 32, source node id.
- edge_dst, input, 32, destination node id.
- edge_last, input, 1, marks the final edge of the graph.
- source_id, output, 32 x [NUM_HW_THREADS][NODES_IN_PARTITION], node id held in each slot.
- out_degree, output, 32 x [NUM_HW_THREADS][NODES_IN_PARTITION], stored edge count per node.
- dest_id, output, 32 x [NUM_HW_THREADS][NODES_IN_PARTITION][STREAM_SIZE], destination ids.
- graph_valid, output, 1, arrays are complete and stable.
- edge_count, output, 32, number of edges stored.
- overflow_err, output, 1, sticky: at least one edge dropped because its source was full.
- range_err, output, 1, sticky: at least one edge dropped because an id was out of range.

Behaviour:
- Placement: node n maps to thread t = n / NODES_IN_PARTITION and slot s = n % NODES_IN_PARTITION.
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - All array outputs, edge_count and both error flags clear to 0.
  - graph_valid = 0, edge_ready = 0.
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE:
  - edge_ready = 0.
  - load_start moves to CLEAR.
- CLEAR:
  - Runs exactly NODES_IN_GRAPH cycles. Counter c runs 0..NODES_IN_GRAPH-1.
  - Each cycle writes slot(c): source_id = c, out_degree = 0, all dest_id entries = 0.
  - On entry, edge_count and both error flags clear.
  - edge_ready = 0.
  - After the final count, moves to LOAD.
- LOAD:
  - edge_ready = 1. A handshake occurs when edge_valid && edge_ready.
  - On handshake, checks are applied in priority order:
    1. edge_src >= NODES_IN_GRAPH or edge_dst >= NODES_IN_GRAPH: range_err <= 1, edge dropped.
    2. Otherwise, if out_degree[src] == STREAM_SIZE: overflow_err <= 1, edge dropped.
    3. Otherwise: dest_id[src][out_degree[src]] <= edge_dst, out_degree[src] increments, edge_count increments.
  - Self-loops and duplicate edges are stored as ordinary edges.
  - Stored results are visible on outputs the cycle after the handshake.
  - A handshake with edge_last moves to DONE, even if that edge was dropped.
  - load_start is ignored in LOAD.
- DONE:
  - graph_valid = 1, asserted the cycle after the last handshake.
  - edge_ready = 0; all outputs are held stable.
  - load_start drops graph_valid the next cycle and moves to CLEAR.
- Throughput: one edge per cycle. Total load latency = NODES_IN_GRAPH + E + 1 cycles after load_start, for E edges with no stalls.
- Reset mid-operation: immediate clear; any partial graph is discarded.
- Reset of the downstream PageRank engine is the integrator's responsibility.
- edge_valid asserted while edge_ready = 0 is not consumed. The source must hold its data per valid/ready rules.
- Node-id-to-thread division uses constant parameters and is synthesisable.
- Indices are truncated to $clog2 widths only after the range check.

Decomposition:
- Package graph_pkg holds:
  - node_id_t (32-bit).
  - FSM state enum loader_state_t.
  - Function node_to_thread(n) and function node_to_slot(n).
  - The same package is shared with pagerank_DMP_serial.
- No sub-module. The FSM plus array registers fit one module; an edge FIFO is the integrator's choice.

Test Plan:
- Load the 20-node benchmark graph (0->{1,4,5}, 1->{2,6}, ..., 15->{16,19}, 18->19, node 19 with no out-edges; 31 edges, last flagged):
  - out_degree[0][0] = 3, out_degree[19][0] = 0, dest_id[15][0] = {16,19,0}.
  - edge_count = 31, graph_valid = 1 exactly 52 cycles after load_start.
- Overflow: edges 0->1, 0->2, 0->3, then 0->4 with edge_last:
  - out_degree[0][0] = 3, dest_id[0][0] = {1,2,3}.
  - overflow_err = 1, edge_count = 3, graph_valid = 1.
- Range: edge 20->1, then 3->25 (last):
  - range_err = 1, edge_count = 0, out_degree all 0.
  - source_id[k][0] = k for all k.
- Backpressure: edge_valid held high from the load_start cycle:
  - edge_ready stays 0 for 20 CLEAR cycles.
  - The first edge is accepted on cycle 22 and is stored exactly once.
- Reset mid-LOAD after 5 edges:
  - Next cycle: all outputs 0, state IDLE, graph_valid = 0.
- Reload from DONE with a second 2-edge graph:
  - Prior edges are gone; edge_count = 2.
  - graph_valid low from the cycle after load_start until the new last handshake + 1.
